// File: rtl/aes_round_seq_if.sv
// Bundle of the request side (round start/result) and the AES byte/column
// unit side (operation request/response) of the round sequencer.
interface aes_round_seq_if;
  logic         start;
  logic         dec;
  logic         last;
  logic [127:0] state_in;
  logic [127:0] rkey;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic         aes_valid;
  logic         aes_dec;
  logic         aes_mix;
  logic [31:0]  aes_rs1;
  logic         aes_ready;
  logic [31:0]  aes_rd;

  // Environment view: issues rounds and plays the AES column unit.
  modport master (
    output start, dec, last, state_in, rkey, aes_ready, aes_rd,
    input  busy, done, state_out, aes_valid, aes_dec, aes_mix, aes_rs1
  );

  // Sequencer view.
  modport slave (
    input  start, dec, last, state_in, rkey, aes_ready, aes_rd,
    output busy, done, state_out, aes_valid, aes_dec, aes_mix, aes_rs1
  );
endinterface

// File: rtl/aes_round_seq.sv
// One AES round (forward or inverse, optionally final) sequenced over an
// external 32-bit SubBytes/MixColumns column unit. Column c of the 128-bit
// state is bits [32c+31:32c], row r of a column is bits [8r+7:8r].
module aes_round_seq #(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic           g_clk,
  input  logic           g_reset,
  aes_round_seq_if.slave bus
);

  // Low two bits of SUB/MIX encodings are the column being processed.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_DONE = 4'd1,
    S_SUB0 = 4'd4,
    S_SUB1 = 4'd5,
    S_SUB2 = 4'd6,
    S_SUB3 = 4'd7,
    S_MIX0 = 4'd8,
    S_MIX1 = 4'd9,
    S_MIX2 = 4'd10,
    S_MIX3 = 4'd11
  } state_t;

  // Forward: out(r,c)=in(r,c+r); inverse: out(r,c)=in(r,c-r), both mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] in_v, input logic inv);
    logic [127:0] out_v;
    logic [1:0]   src;
    out_v = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 2'(c - r) : 2'(c + r);
        out_v[32*c + 8*r +: 8] = in_v[{src, 5'd0} + 7'(8*r) +: 8];
      end
    end
    return out_v;
  endfunction

  function automatic logic [31:0] col_get(input logic [127:0] st_v, input logic [1:0] idx);
    return st_v[{idx, 5'd0} +: 32];
  endfunction

  function automatic logic [127:0] col_set(input logic [127:0] st_v, input logic [1:0] idx,
                                           input logic [31:0] val);
    logic [127:0] res;
    res = st_v;
    res[{idx, 5'd0} +: 32] = val;
    return res;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic         dec_q, dec_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] state_out_q, state_out_d;
  logic         valid_q, valid_d;
  logic         mix_q, mix_d;
  logic [31:0]  rs1_q, rs1_d;
  logic         hs_s;
  logic [127:0] upd_s;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = state_out_q;
  assign bus.aes_valid = valid_q;
  assign bus.aes_dec   = dec_q;
  assign bus.aes_mix   = mix_q;
  assign bus.aes_rs1   = rs1_q;

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    key_d       = key_q;
    dec_d       = dec_q;
    last_d      = last_q;
    state_out_d = state_out_q;
    done_d      = 1'b0;
    hs_s        = valid_q & bus.aes_ready;
    upd_s       = col_set(st_q, state_q[1:0], bus.aes_rd);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dec_d   = bus.dec & DECRYPT_EN;
          last_d  = bus.last;
          key_d   = bus.rkey;
          st_d    = dec_d ? shift_rows(bus.state_in, 1'b1) : bus.state_in;
          state_d = S_SUB0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SUB0, S_SUB1, S_SUB2, S_MIX0, S_MIX1, S_MIX2: begin
        if (hs_s) begin
          st_d    = upd_s;
          state_d = state_t'(state_q + 4'd1);
        end else begin
          state_d = state_q;
        end
      end
      S_SUB3: begin
        if (hs_s) begin
          if (dec_q) begin
            st_d = upd_s ^ key_q;
          end else if (last_q) begin
            st_d = shift_rows(upd_s, 1'b0) ^ key_q;
          end else begin
            st_d = shift_rows(upd_s, 1'b0);
          end
          state_d = last_q ? S_DONE : S_MIX0;
        end else begin
          state_d = S_SUB3;
        end
      end
      S_MIX3: begin
        if (hs_s) begin
          st_d    = dec_q ? upd_s : (upd_s ^ key_q);
          state_d = S_DONE;
        end else begin
          state_d = S_MIX3;
        end
      end
      S_DONE: begin
        state_out_d = st_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_SUB0, S_SUB1, S_SUB2, S_SUB3: begin
        valid_d = 1'b1;
        mix_d   = 1'b0;
      end
      S_MIX0, S_MIX1, S_MIX2, S_MIX3: begin
        valid_d = 1'b1;
        mix_d   = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        mix_d   = 1'b0;
      end
    endcase

    if (valid_d) begin
      rs1_d = col_get(st_d, state_d[1:0]);
    end else begin
      rs1_d = 32'd0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= S_IDLE;
      st_q        <= 128'd0;
      key_q       <= 128'd0;
      dec_q       <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      state_out_q <= 128'd0;
      valid_q     <= 1'b0;
      mix_q       <= 1'b0;
      rs1_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      state_out_q <= state_out_d;
      valid_q     <= valid_d;
      mix_q       <= mix_d;
      rs1_q       <= rs1_d;
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq with a behavioural AES column unit.
module tb_aes_round_seq;

  logic g_clk = 1'b0;
  logic g_reset;
  always #5 g_clk = ~g_clk;

  aes_round_seq_if bus ();
  aes_round_seq_if bus2 ();

  aes_round_seq #(.DECRYPT_EN(1'b1)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  aes_round_seq #(.DECRYPT_EN(1'b0)) dut_nodec (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus2)
  );

  int errors = 0;
  int checks = 0;

  // Responder configuration (written by the test sequence only).
  int sub_wait = 1;
  int mix_wait = 1;
  bit rand_mode = 1'b0;

  // Responder bookkeeping (written by the responder only).
  int          sub_hs = 0;
  int          mix_hs = 0;
  int          stab_viol = 0;
  int          mix_issue = 0;
  logic [31:0] hs_log = 32'd0;
  bit          op_active = 1'b0;
  int          op_cyc = 0;
  logic [31:0] s_rs1;
  logic        s_mix, s_dec;
  int          nodec_dec_seen = 0;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] unit_op(input logic [31:0] rs1, input logic mix, input logic dec);
    logic [7:0]  a [4];
    logic [7:0]  cf [4];
    logic [7:0]  b;
    logic [31:0] res;
    res = 32'd0;
    for (int r = 0; r < 4; r++) a[r] = rs1[8*r +: 8];
    if (dec) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    for (int r = 0; r < 4; r++) begin
      if (!mix) begin
        res[8*r +: 8] = dec ? inv_sbox(a[r]) : sbox(a[r]);
      end else begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(cf[(j - r + 4) % 4], a[j]);
        res[8*r +: 8] = b;
      end
    end
    return res;
  endfunction

  // FIPS-197 hex strings list byte 0 first; the DUT wants byte 0 in bits [7:0].
  function automatic logic [127:0] fips(input logic [127:0] v);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = v[8*(15-k) +: 8];
    return o;
  endfunction

  logic [127:0] FIPS_IN, FIPS_KEY, FIPS_OUT;

  // AES column unit for the main DUT: configurable or random latency,
  // operand-stability monitor, handshake log (1 = MixColumns, newest in LSB).
  always @(negedge g_clk) begin
    if (bus.aes_valid === 1'b1) begin
      if (!op_active) begin
        op_active = 1'b1;
        op_cyc    = 1;
        s_rs1     = bus.aes_rs1;
        s_mix     = bus.aes_mix;
        s_dec     = bus.aes_dec;
        if (bus.aes_mix) mix_issue++;
      end else begin
        op_cyc++;
        if (bus.aes_rs1 !== s_rs1 || bus.aes_mix !== s_mix || bus.aes_dec !== s_dec) stab_viol++;
      end
      if (rand_mode) bus.aes_ready = ($urandom_range(0, 2) == 0);
      else           bus.aes_ready = (op_cyc >= (bus.aes_mix ? mix_wait : sub_wait));
      if (bus.aes_ready) begin
        bus.aes_rd = unit_op(bus.aes_rs1, bus.aes_mix, bus.aes_dec);
        op_active  = 1'b0;
        hs_log     = {hs_log[30:0], bus.aes_mix};
        if (bus.aes_mix) mix_hs++;
        else             sub_hs++;
      end else begin
        bus.aes_rd = $urandom();
      end
    end else begin
      op_active     = 1'b0;
      bus.aes_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
      bus.aes_rd    = $urandom();
    end
  end

  // Zero-wait column unit for the DECRYPT_EN=0 instance.
  always @(negedge g_clk) begin
    bus2.aes_ready = 1'b1;
    bus2.aes_rd    = unit_op(bus2.aes_rs1, bus2.aes_mix, bus2.aes_dec);
    if (bus2.aes_dec === 1'b1) nodec_dec_seen++;
  end

  task automatic start_round(input logic d, input logic l, input logic [127:0] s, input logic [127:0] k);
    bus.dec = d; bus.last = l; bus.state_in = s; bus.rkey = k; bus.start = 1'b1;
  endtask

  // Runs a fixed number of cycles after the start cycle; reports the first
  // done cycle (-1 if none) and the number of done pulses. poke_cyc > 0
  // pulses a bogus start during that cycle.
  task automatic run_cycles(input int budget, input int poke_cyc, output int done_cyc, output int pulses);
    done_cyc = -1;
    pulses   = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge g_clk); #1;
      if (c == 1) bus.start = 1'b0;
      if (c == poke_cyc) begin
        bus.start = 1'b1; bus.dec = 1'b1; bus.last = 1'b1;
        bus.state_in = 128'd0; bus.rkey = {128{1'b1}};
      end else if (c == poke_cyc + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    repeat (3) @(posedge g_clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.aes_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.aes_valid); end
    checks++; if (bus.aes_mix !== 1'b0) begin errors++; $display("FAIL reset_mix: got %b want 0", bus.aes_mix); end
    checks++; if (bus.aes_dec !== 1'b0) begin errors++; $display("FAIL reset_dec: got %b want 0", bus.aes_dec); end
    checks++; if (bus.aes_rs1 !== 32'd0) begin errors++; $display("FAIL reset_rs1: got %h want 0", bus.aes_rs1); end
    checks++; if (bus.state_out !== 128'd0) begin errors++; $display("FAIL reset_state_out: got %h want 0", bus.state_out); end
    g_reset = 1'b0;
  endtask

  task automatic test_fips_enc();
    int dc, p, b_sub, b_mix;
    sub_wait = 1; mix_wait = 1;
    b_sub = sub_hs; b_mix = mix_hs;
    start_round(1'b0, 1'b0, FIPS_IN, FIPS_KEY);
    run_cycles(30, 0, dc, p);
    checks++; if (bus.state_out !== FIPS_OUT) begin errors++; $display("FAIL fips_enc_result: got %h want %h", bus.state_out, FIPS_OUT); end
    checks++; if (dc !== 10) begin errors++; $display("FAIL fips_enc_latency: got %0d want 10", dc); end
    checks++; if (p !== 1) begin errors++; $display("FAIL fips_enc_pulses: got %0d want 1", p); end
    checks++; if (sub_hs - b_sub !== 4 || mix_hs - b_mix !== 4) begin errors++;
      $display("FAIL fips_enc_hs: got sub=%0d mix=%0d want 4/4", sub_hs - b_sub, mix_hs - b_mix); end
    checks++; if (hs_log[7:0] !== 8'h0f) begin errors++; $display("FAIL fips_enc_order: got %b want 00001111", hs_log[7:0]); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fips_enc_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_last_enc();
    int dc, p, b_mi;
    b_mi = mix_issue;
    start_round(1'b0, 1'b1, 128'd0, 128'd0);
    run_cycles(20, 0, dc, p);
    checks++; if (bus.state_out !== {16{8'h63}}) begin errors++; $display("FAIL last_enc_result: got %h want all 63", bus.state_out); end
    checks++; if (mix_issue - b_mi !== 0) begin errors++; $display("FAIL last_enc_no_mix: got %0d mix ops want 0", mix_issue - b_mi); end
    checks++; if (dc !== 6 || p !== 1) begin errors++; $display("FAIL last_enc_done: got cycle %0d pulses %0d want 6/1", dc, p); end
  endtask

  task automatic test_latency();
    int dc, p, b_sub, b_mix;
    sub_wait = 5; mix_wait = 1;
    b_sub = sub_hs; b_mix = mix_hs;
    start_round(1'b0, 1'b0, FIPS_IN, FIPS_KEY);
    run_cycles(40, 10, dc, p);
    checks++; if (dc !== 26) begin errors++; $display("FAIL latency_done_cycle: got %0d want 26", dc); end
    checks++; if (p !== 1) begin errors++; $display("FAIL latency_pulses: got %0d want 1", p); end
    checks++; if (sub_hs - b_sub !== 4 || mix_hs - b_mix !== 4) begin errors++;
      $display("FAIL latency_hs: got sub=%0d mix=%0d want 4/4", sub_hs - b_sub, mix_hs - b_mix); end
    checks++; if (hs_log[7:0] !== 8'h0f) begin errors++; $display("FAIL latency_order: got %b want 00001111", hs_log[7:0]); end
    checks++; if (bus.state_out !== FIPS_OUT) begin errors++; $display("FAIL latency_ignored_start: got %h want %h", bus.state_out, FIPS_OUT); end
    sub_wait = 1;
  endtask

  task automatic test_last_dec();
    int dc, p;
    start_round(1'b1, 1'b1, 128'd0, 128'd0);
    run_cycles(20, 0, dc, p);
    checks++; if (bus.state_out !== {16{8'h52}}) begin errors++; $display("FAIL last_dec_result: got %h want all 52", bus.state_out); end
    checks++; if (dc !== 6 || p !== 1) begin errors++; $display("FAIL last_dec_done: got cycle %0d pulses %0d want 6/1", dc, p); end
  endtask

  task automatic test_stalls();
    int dc, p, b_sv;
    b_sv = stab_viol;
    rand_mode = 1'b1;
    start_round(1'b0, 1'b0, FIPS_IN, FIPS_KEY);
    run_cycles(300, 0, dc, p);
    rand_mode = 1'b0;
    checks++; if (bus.state_out !== FIPS_OUT) begin errors++; $display("FAIL stalls_result: got %h want %h", bus.state_out, FIPS_OUT); end
    checks++; if (stab_viol - b_sv !== 0) begin errors++; $display("FAIL stalls_operand_stable: got %0d changes want 0", stab_viol - b_sv); end
    checks++; if (p !== 1) begin errors++; $display("FAIL stalls_pulses: got %0d want 1", p); end
    checks++; if (hs_log[7:0] !== 8'h0f) begin errors++; $display("FAIL stalls_order: got %b want 00001111", hs_log[7:0]); end
  endtask

  task automatic test_reset_mid();
    int dc, p, b_mix, c;
    bit found;
    sub_wait = 1; mix_wait = 2;
    b_mix = mix_hs;
    found = 1'b0;
    start_round(1'b0, 1'b0, FIPS_IN, FIPS_KEY);
    c = 0;
    while (!found && c < 40) begin
      c++;
      @(posedge g_clk); #1;
      if (c == 1) bus.start = 1'b0;
      if (bus.aes_valid === 1'b1 && bus.aes_mix === 1'b1 && mix_hs - b_mix == 1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_mid_reach_mix1: got no MIX1 within %0d cycles want MIX1", c); end
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.aes_valid !== 1'b0) begin errors++;
      $display("FAIL reset_mid_idle: got busy=%b valid=%b want 0/0", bus.busy, bus.aes_valid); end
    checks++; if (bus.state_out !== 128'd0) begin errors++; $display("FAIL reset_mid_state_out: got %h want 0", bus.state_out); end
    run_cycles(20, 0, dc, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", p); end
    mix_wait = 1;
    start_round(1'b0, 1'b0, FIPS_IN, FIPS_KEY);
    run_cycles(30, 0, dc, p);
    checks++; if (bus.state_out !== FIPS_OUT || dc !== 10) begin errors++;
      $display("FAIL reset_mid_restart: got %h at cycle %0d want %h at 10", bus.state_out, dc, FIPS_OUT); end
  endtask

  task automatic test_nodec();
    int dc;
    dc = -1;
    bus2.dec = 1'b1; bus2.last = 1'b1; bus2.state_in = 128'd0; bus2.rkey = 128'd0; bus2.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge g_clk); #1;
      if (c == 1) bus2.start = 1'b0;
      if (bus2.done === 1'b1 && dc < 0) dc = c;
    end
    checks++; if (bus2.state_out !== {16{8'h63}}) begin errors++; $display("FAIL nodec_result: got %h want all 63", bus2.state_out); end
    checks++; if (nodec_dec_seen !== 0) begin errors++; $display("FAIL nodec_aes_dec: got %0d cycles high want 0", nodec_dec_seen); end
    checks++; if (dc !== 6) begin errors++; $display("FAIL nodec_done_cycle: got %0d want 6", dc); end
  endtask

  initial begin
    FIPS_IN  = fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    FIPS_KEY = fips(128'ha0fafe1788542cb123a339392a6c7605);
    FIPS_OUT = fips(128'ha49c7ff2689f352b6b5bea43026a5049);
    g_reset = 1'b1;
    bus.start = 1'b0; bus.dec = 1'b0; bus.last = 1'b0; bus.state_in = 128'd0; bus.rkey = 128'd0;
    bus2.start = 1'b0; bus2.dec = 1'b0; bus2.last = 1'b0; bus2.state_in = 128'd0; bus2.rkey = 128'd0;
    test_reset();
    test_fips_enc();
    test_last_enc();
    test_latency();
    test_last_dec();
    test_stalls();
    test_reset_mid();
    test_nodec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 Parameter DECRYPT_EN, default 1, SHALL enable dec=1 operation; when 0, dec is treated as 0.
REQ-002 g_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 g_reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 start  input  1  SHALL request one AES round; sampled only in IDLE.
REQ-005 dec  input  1  SHALL select encrypt round (0) or inverse round (1); captured at start.
REQ-006 last  input  1  SHALL select final round (no MixColumns); captured at start.
REQ-007 state_in  input  128  SHALL carry the round input state; byte k of the FIPS-197 sequence is at bits [8k+7:8k]; captured at start.
REQ-008 rkey  input  128  SHALL carry the round key, same byte order; captured at start.
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when state_out is updated.
REQ-011 state_out  output  128  SHALL hold the round result from done until the next done.
REQ-012 aes_valid  output  1  SHALL request an operation from the AES byte/column unit.
REQ-013 aes_dec  output  1  SHALL drive the unit's decrypt select.
REQ-014 aes_mix  output  1  SHALL drive the unit's op select: 1 MixColumns, 0 SubBytes.
REQ-015 aes_rs1  output  32  SHALL drive the unit's 32-bit column operand.
REQ-016 aes_ready  input  1  SHALL indicate the unit's result is available this cycle.
REQ-017 aes_rd  input  32  SHALL carry the unit's result; sampled only on handshake.

Function
REQ-018 Column c SHALL be bits [32c+31:32c]; row r of a column SHALL be bits [8r+7:8r].
REQ-019 Handshake SHALL occur on a cycle with aes_valid=1 and aes_ready=1; aes_dec, aes_mix, aes_rs1 SHALL be held stable from assertion until handshake.
REQ-020 The cycle after a handshake SHALL present the next operation (aes_valid stays high) or aes_valid=0 if none remains; no bubble is inserted.
REQ-021 States: IDLE, SUB0-SUB3, MIX0-MIX3, DONE.
REQ-022 IDLE: start=1 SHALL capture inputs into internal state register st and key register, then go to SUB0; start=0 stays IDLE.
REQ-023 Encrypt capture SHALL store state_in unchanged; inverse capture SHALL store InvShiftRows(state_in), out(r,c)=in(r,(c-r) mod 4).
REQ-024 SUBc SHALL issue aes_mix=0, aes_rs1=st column c; on handshake column c of st SHALL be replaced by aes_rd and SUBc advances to SUB(c+1); SUB3 advances per REQ-025.
REQ-025 On SUB3 handshake: encrypt SHALL apply ShiftRows, out(r,c)=in(r,(c+r) mod 4), to the updated st, and XOR rkey if last=1; inverse SHALL XOR rkey into the updated st; next state MIX0, or DONE if last=1.
REQ-026 MIXc SHALL issue aes_mix=1, aes_rs1=st column c; on handshake column c SHALL be replaced by aes_rd.
REQ-027 On MIX3 handshake, encrypt SHALL XOR rkey into st; both modes go to DONE.
REQ-028 DONE SHALL load state_out from st, assert done for that cycle, return to IDLE; aes_valid=0 in DONE and IDLE.
REQ-029 aes_dec SHALL equal the captured dec (gated by DECRYPT_EN) throughout a round.
REQ-030 start while busy SHALL be ignored with no effect on the current round.
REQ-031 Latency: with SubBytes handshakes N cycles after issue and MixColumns handshakes in the issue cycle, done SHALL assert 1+4N+4+1 cycles after the start cycle (last=0), 1+4N+1 (last=1).
REQ-032 aes_ready high without aes_valid SHALL be ignored.

Reset
REQ-033 While g_reset=1 at a clock edge: state IDLE, busy=0, done=0, aes_valid=0, aes_mix=0, aes_dec=0, aes_rs1=0, state_out=0, st=0.
REQ-034 Reset mid-round SHALL abandon the round: next cycle aes_valid=0, no done pulse, state_out=0.

Verification
REQ-035 FIPS-197 App. B round 1, dec=0, last=0, state_in=193de3bea0f4e22b9ac68d2ae9f84808, rkey=a0fafe1788542cb123a339392a6c7605 (FIPS byte order) -> state_out=a49c7ff2689f352b6b5bea43026a5049, single done pulse.
REQ-036 dec=0, last=1, state_in=0, rkey=0 -> every byte of state_out=0x63; no aes_mix=1 issued.
REQ-037 dec=1, last=1, state_in=0, rkey=0 -> every byte 0x52; with DECRYPT_EN=0 -> every byte 0x63.
REQ-038 Responder with 5-cycle SubBytes and 0-wait MixColumns, start at cycle 0, last=0 -> done at cycle 26; exactly 4 SubBytes then 4 MixColumns handshakes; start pulsed at cycle 10 ignored.
REQ-039 Random aes_ready stalls -> operands stable until handshake, result identical to REQ-035.
REQ-040 g_reset asserted during MIX1 -> next cycle busy=0, aes_valid=0, state_out=0, no done; a following start completes normally.
